muldiv_seq: RTL

- Iterative 32-bit multiply/divide sequencer that produces HI/LO results for MULT(U)/DIV(U).
- Does not contain its own adder. It borrows the datapath's shared ALU for one add or subtract per iteration, and drives the ALU's A/B/ALUOp inputs through a datapath mux while it owns the ALU.
- Sits beside the ALU in the execute stage. The hazard unit stalls the pipeline while busy=1.

---
 rtl/muldiv_seq_pkg.sv | 64 ++++++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared types, encodings and ALU-drive helper for the muldiv_seq sequencer.
// ALU opcode values mirror the ALU_* encodings of the datapath's ctrl_encode_def.v.
package muldiv_seq_pkg;

    localparam int unsigned MDS_ITERS = 32;
    localparam int unsigned MDS_W     = 32;
    localparam int unsigned MDS_OPW   = 4;

    localparam logic [MDS_OPW-1:0] ALU_NOP = 4'b0000;
    localparam logic [MDS_OPW-1:0] ALU_ADD = 4'b0001;
    localparam logic [MDS_OPW-1:0] ALU_SUB = 4'b0010;

    typedef enum logic [2:0] {
        MDS_IDLE = 3'd0,
        MDS_MUL  = 3'd1,
        MDS_DIV  = 3'd2,
        MDS_FIX  = 3'd3,
        MDS_DONE = 3'd4
    } mds_state_t;

    typedef struct packed {
        logic               own;
        logic [MDS_W-1:0]   a;
        logic [MDS_W-1:0]   b;
        logic [MDS_OPW-1:0] op;
    } alu_drive_t;

    // ALU request for a given state and register contents (acc = P_hi/R, lor = P_lo/Q, opnd = M/D)
    function automatic alu_drive_t mds_alu_drive(
        input mds_state_t       st,
        input logic [MDS_W-1:0] acc,
        input logic [MDS_W-1:0] lor,
        input logic [MDS_W-1:0] opnd
    );
        alu_drive_t d;
        d.own = 1'b0;
        d.a   = '0;
        d.b   = '0;
        d.op  = ALU_NOP;
        case (st)
            MDS_MUL: begin
                d.own = 1'b1;
                d.a   = acc;
                d.b   = opnd;
                d.op  = lor[0] ? ALU_ADD : ALU_NOP;
            end
            MDS_DIV: begin
                d.own = 1'b1;
                d.a   = {acc[MDS_W-2:0], lor[MDS_W-1]};
                d.b   = opnd;
                d.op  = ALU_SUB;
            end
            MDS_FIX: begin
                d.own = 1'b1;
                d.a   = '0;
                d.b   = lor;
                d.op  = ALU_SUB;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational per-iteration update for shift-add multiply and restoring divide,
// consuming the shared ALU's result for the current iteration.
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic             is_div,
    input  logic [MDS_W-1:0] acc,
    input  logic [MDS_W-1:0] lor,
    input  logic [MDS_W-1:0] alu_c,
    output logic [MDS_W-1:0] acc_nx_c,
    output logic [MDS_W-1:0] lor_nx_c
);

    logic [MDS_W-1:0] s;
    logic             carry;
    logic             ge;

    always_comb begin
        s     = {acc[MDS_W-2:0], lor[MDS_W-1]};
        carry = lor[0] & (alu_c < acc);
        // with a non-zero divisor, a wrapped difference is always larger than s
        ge    = acc[MDS_W-1] | (alu_c <= s);
        if (is_div) begin
            acc_nx_c = ge ? alu_c : s;
            lor_nx_c = {lor[MDS_W-2:0], ge};
        end else begin
            acc_nx_c = {carry, alu_c[MDS_W-1:1]};
            lor_nx_c = {alu_c[0], lor[MDS_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide sequencer borrowing the shared execute-stage ALU.
// Optional signed support (magnitude conversion + FIX cycle) under `MULDIV_SIGNED_EN.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned ITERS = MDS_ITERS
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               flush,
    input  logic               op_div,
    input  logic               op_signed,
    input  logic [MDS_W-1:0]   opa,
    input  logic [MDS_W-1:0]   opb,
    output logic               busy,
    output logic               done,
    output logic [MDS_W-1:0]   hi,
    output logic [MDS_W-1:0]   lo,
    output logic               alu_own,
    output logic [MDS_W-1:0]   alu_a,
    output logic [MDS_W-1:0]   alu_b,
    output logic [MDS_OPW-1:0] alu_op,
    input  logic [MDS_W-1:0]   alu_c
);

    localparam int unsigned CW = $clog2(ITERS);

    mds_state_t       state, state_nx;
    logic [MDS_W-1:0] acc, acc_nx;
    logic [MDS_W-1:0] lor, lor_nx;
    logic [MDS_W-1:0] opnd, opnd_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [MDS_W-1:0] step_acc, step_lor;
    logic [MDS_W-1:0] opa_m, opb_m;
    logic             step_div;
    logic             last_iter;
    alu_drive_t       drv_nx;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic fix_q, fix_nx;
    logic sgn_res, sgn_res_nx;
    logic sgn_rem, sgn_rem_nx;
    logic div_q, div_q_nx;

    // operand magnitudes are formed locally so the ALU is only needed for iterations
    assign a_neg = op_signed & opa[MDS_W-1];
    assign b_neg = op_signed & opb[MDS_W-1];
    assign opa_m = a_neg ? (~opa + MDS_W'(1)) : opa;
    assign opb_m = b_neg ? (~opb + MDS_W'(1)) : opb;
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign opa_m = opa;
    assign opb_m = opb;
`endif

    assign step_div  = (state == MDS_DIV);
    assign last_iter = (cnt == CW'(ITERS - 1));

    muldiv_step u_step (
        .is_div   (step_div),
        .acc      (acc),
        .lor      (lor),
        .alu_c    (alu_c),
        .acc_nx_c (step_acc),
        .lor_nx_c (step_lor)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= MDS_IDLE;
        else       state <= state_nx;
    end

    // next state and next datapath register values
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        lor_nx   = lor;
        opnd_nx  = opnd;
        cnt_nx   = cnt;
`ifdef MULDIV_SIGNED_EN
        fix_nx     = fix_q;
        sgn_res_nx = sgn_res;
        sgn_rem_nx = sgn_rem;
        div_q_nx   = div_q;
`endif
        unique case (state)
            MDS_IDLE: begin
                if (start) begin
                    cnt_nx = '0;
`ifdef MULDIV_SIGNED_EN
                    fix_nx     = op_signed;
                    sgn_res_nx = a_neg ^ b_neg;
                    sgn_rem_nx = a_neg;
                    div_q_nx   = op_div;
`endif
                    if (op_div && (opb == '0)) begin
                        state_nx = MDS_DONE;
                        acc_nx   = opa;
                        lor_nx   = '1;
`ifdef MULDIV_SIGNED_EN
                        fix_nx   = 1'b0;
`endif
                    end else if (op_div) begin
                        state_nx = MDS_DIV;
                        acc_nx   = '0;
                        lor_nx   = opa_m;
                        opnd_nx  = opb_m;
                    end else begin
                        state_nx = MDS_MUL;
                        acc_nx   = '0;
                        lor_nx   = opb_m;
                        opnd_nx  = opa_m;
                    end
                end
            end
            MDS_MUL, MDS_DIV: begin
                acc_nx = step_acc;
                lor_nx = step_lor;
                cnt_nx = cnt + CW'(1);
                if (last_iter) begin
`ifdef MULDIV_SIGNED_EN
                    state_nx = fix_q ? MDS_FIX : MDS_DONE;
`else
                    state_nx = MDS_DONE;
`endif
                end
            end
            MDS_FIX: begin
`ifdef MULDIV_SIGNED_EN
                // ALU computes 0 - lor; the high word is negated here with the borrow
                state_nx = MDS_DONE;
                if (sgn_res) lor_nx = alu_c;
                if (div_q) begin
                    if (sgn_rem) acc_nx = ~acc + MDS_W'(1);
                end else if (sgn_res) begin
                    acc_nx = ~acc + MDS_W'(lor == '0);
                end
`else
                state_nx = MDS_IDLE;
`endif
            end
            MDS_DONE: state_nx = MDS_IDLE;
            default:  state_nx = MDS_IDLE;
        endcase
        if (flush) state_nx = MDS_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc  <= '0;
            lor  <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else begin
            acc  <= acc_nx;
            lor  <= lor_nx;
            opnd <= opnd_nx;
            cnt  <= cnt_nx;
        end
    end

`ifdef MULDIV_SIGNED_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fix_q   <= 1'b0;
            sgn_res <= 1'b0;
            sgn_rem <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            fix_q   <= fix_nx;
            sgn_res <= sgn_res_nx;
            sgn_rem <= sgn_rem_nx;
            div_q   <= div_q_nx;
        end
    end
`endif

    assign drv_nx = mds_alu_drive(state_nx, acc_nx, lor_nx, opnd_nx);

    // status, results and ALU drive are registered from next-cycle values
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            alu_own <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= ALU_NOP;
        end else begin
            busy    <= (state_nx != MDS_IDLE);
            done    <= (state_nx == MDS_DONE);
            alu_own <= drv_nx.own;
            alu_a   <= drv_nx.a;
            alu_b   <= drv_nx.b;
            alu_op  <= drv_nx.op;
            if (state_nx == MDS_DONE) begin
                hi <= acc_nx;
                lo <= lor_nx;
            end
        end
    end

endmodule
